// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation valve sequencer.
package irrigation_pkg;

  localparam logic [1:0] MODE_NONE      = 2'b00;
  localparam logic [1:0] MODE_DRIP      = 2'b01;
  localparam logic [1:0] MODE_SPRINKLER = 2'b10;
  localparam logic [1:0] MODE_AUTO      = 2'b11;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StGuard = 3'd1,
    StWater = 3'd2,
    StFill  = 3'd3,
    StFault = 3'd4
  } state_e;

  typedef enum logic {
    SelDrip      = 1'b0,
    SelSprinkler = 1'b1
  } sel_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/irrigation_sequencer_if.sv
// Sensor/mode inputs and valve/status outputs of the irrigation sequencer.
interface irrigation_sequencer_if;
  logic [1:0] mode;
  logic       soil_dry;
  logic       soil_very_dry;
  logic       tank_low;
  logic       tank_full;
  logic       valve_sprinkler;
  logic       valve_drip;
  logic       valve_fill;
  logic       busy;
  logic       alarm;
  logic [2:0] state;

  modport master (
    output mode, soil_dry, soil_very_dry, tank_low, tank_full,
    input  valve_sprinkler, valve_drip, valve_fill, busy, alarm, state
  );

  modport slave (
    input  mode, soil_dry, soil_very_dry, tank_low, tank_full,
    output valve_sprinkler, valve_drip, valve_fill, busy, alarm, state
  );
endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntLast);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/irrigation_sequencer.sv
// Valve sequencer: synchronizes sensors, guards valve opening with a dead time,
// bounds watering/refill by a tick timer and latches faults.
module irrigation_sequencer
  import irrigation_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned GUARD_TICKS = 2,
  parameter int unsigned WATER_MAX   = 600,
  parameter int unsigned FILL_MAX    = 300
) (
  input logic                   clk,
  input logic                   reset_n,
  irrigation_sequencer_if.slave ctrl_io
);

  localparam int unsigned TimerW = $clog2(max3(GUARD_TICKS, WATER_MAX, FILL_MAX)) + 1;
  // Compare against N-1: the limit fires on the Nth tick itself, not one cycle later.
  localparam logic [TimerW-1:0] GuardLast = TimerW'(GUARD_TICKS - 1);
  localparam logic [TimerW-1:0] WaterLast = TimerW'(WATER_MAX - 1);
  localparam logic [TimerW-1:0] FillLast  = TimerW'(FILL_MAX - 1);

  logic tick;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  logic [5:0] sync1_q, sync2_q;
  logic [1:0] mode_s;
  logic       soil_dry_s, soil_very_dry_s, tank_low_s, tank_full_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {ctrl_io.mode, ctrl_io.soil_dry, ctrl_io.soil_very_dry,
                  ctrl_io.tank_low, ctrl_io.tank_full};
      sync2_q <= sync1_q;
    end
  end

  assign {mode_s, soil_dry_s, soil_very_dry_s, tank_low_s, tank_full_s} = sync2_q;

  logic moist_dry;
  logic demand_vld;
  sel_e demand_sel;

  assign moist_dry = soil_dry_s | soil_very_dry_s;

  always_comb begin
    demand_vld = 1'b0;
    demand_sel = SelDrip;
    case (mode_s)
      MODE_DRIP:      demand_vld = moist_dry;
      MODE_SPRINKLER: begin
        demand_vld = moist_dry;
        demand_sel = SelSprinkler;
      end
      MODE_AUTO:      begin
        demand_vld = moist_dry;
        demand_sel = soil_very_dry_s ? SelSprinkler : SelDrip;
      end
      default:        ;
    endcase
  end

  state_e            state_q, state_d;
  sel_e              sel_q, sel_d;
  logic [1:0]        mode_ref_q, mode_ref_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              guard_done, water_done, fill_done;

  assign guard_done = tick && (timer_q >= GuardLast);
  assign water_done = tick && (timer_q >= WaterLast);
  assign fill_done  = tick && (timer_q >= FillLast);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    mode_ref_d = mode_ref_q;
    if (tank_low_s && tank_full_s) begin
      state_d = StFault;
    end else begin
      case (state_q)
        StIdle: begin
          if (tank_low_s) begin
            state_d = StFill;
          end else if (demand_vld) begin
            state_d    = StGuard;
            sel_d      = demand_sel;
            mode_ref_d = mode_s;
          end
        end
        StGuard: if (guard_done) state_d = StWater;
        StWater: begin
          if (tank_low_s) begin
            state_d = StFill;
          end else if (water_done || !moist_dry || (mode_s != mode_ref_q)) begin
            state_d = StIdle;
          end
        end
        StFill: begin
          if (tank_full_s) begin
            state_d = StIdle;
          end else if (fill_done) begin
            state_d = StFault;
          end
        end
        StFault: if (mode_s == MODE_NONE) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Timer restarts on every state entry and saturates rather than wrapping.
  always_comb begin
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (tick && (timer_q != '1)) begin
      timer_d = timer_q + TimerW'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      sel_q      <= SelDrip;
      mode_ref_q <= MODE_NONE;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      mode_ref_q <= mode_ref_d;
      timer_q    <= timer_d;
    end
  end

  assign ctrl_io.valve_sprinkler = (state_q == StWater) && (sel_q == SelSprinkler);
  assign ctrl_io.valve_drip      = (state_q == StWater) && (sel_q == SelDrip);
  assign ctrl_io.valve_fill      = (state_q == StFill);
  assign ctrl_io.busy            = (state_q != StIdle);
  assign ctrl_io.alarm           = (state_q == StFault);
  assign ctrl_io.state           = state_q;

endmodule
